div_unit: RTL

//  Iterative radix-2 restoring divider for DIV/DIVU in the EX stage. Takes operands read from
//  the register file, runs one quotient bit per cycle and returns quotient/remainder, which
//  EX writes to LO/HI through the hi_we/lo_we forwarding path. Raises stall_req so the

---
 rtl/div_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU. It produces one quotient bit per cycle
// and holds the pipeline through stall_req while a divide is in flight.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   output logic             busy,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH:0]   rem_r;
   logic [WIDTH-1:0] dvd_r;
   logic [WIDTH-1:0] dvs_r;
   logic             q_neg_r;
   logic             r_neg_r;
   logic             div0_r;

   logic             accept_s;
   logic             last_s;
   logic             a_neg_s;
   logic             b_neg_s;
   logic [WIDTH:0]   a_abs_s;
   logic [WIDTH:0]   b_abs_s;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH:0]   rem_nxt_s;
   logic [WIDTH-1:0] dvd_nxt_s;
   logic [WIDTH-1:0] q_fix_s;
   logic [WIDTH-1:0] r_fix_s;

   // Magnitudes are formed one bit wider so the most negative operand needs no special case.
   function automatic logic [WIDTH:0] neg_if(input logic neg, input logic [WIDTH:0] val);
      if (neg) begin
         return -val;
      end else begin
         return val;
      end
   endfunction

   // Handshake decode: accept, final iteration, and the pipeline-facing status flags.
   always_comb begin
      accept_s  = (state_r == IDLE) && start && !cancel;
      last_s    = (state_r == CALC) && (cnt_r == LAST_CNT) && !cancel;
      stall_req = accept_s || (state_r == CALC);
      busy      = (state_r == CALC) || (state_r == DONE);
      done      = (state_r == DONE) && !cancel;
   end

   // Next-state logic; cancel always returns to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start && !cancel) begin
               state_nxt_s = CALC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            if (cancel) begin
               state_nxt_s = IDLE;
            end else if (cnt_r == LAST_CNT) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = CALC;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Operand conditioning, one restoring step, and final sign fix-up.
   always_comb begin
      a_neg_s = is_signed && dividend[WIDTH-1];
      b_neg_s = is_signed && divisor[WIDTH-1];
      a_abs_s = neg_if(a_neg_s, {a_neg_s, dividend});
      b_abs_s = neg_if(b_neg_s, {b_neg_s, divisor});
      trial_s = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};
      if (trial_s >= {1'b0, dvs_r}) begin
         rem_nxt_s = trial_s - {1'b0, dvs_r};
         dvd_nxt_s = {dvd_r[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt_s = trial_s;
         dvd_nxt_s = {dvd_r[WIDTH-2:0], 1'b0};
      end
      // Divide by zero leaves Q all ones and R = |dividend|; negating R restores the raw dividend.
      if (div0_r) begin
         q_fix_s = dvd_nxt_s;
      end else begin
         q_fix_s = q_neg_r ? -dvd_nxt_s : dvd_nxt_s;
      end
      r_fix_s = r_neg_r ? -rem_nxt_s[WIDTH-1:0] : rem_nxt_s[WIDTH-1:0];
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand capture on accept, then one shift/subtract per CALC cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_r   <= {CW{1'b0}};
         rem_r   <= {(WIDTH + 1){1'b0}};
         dvd_r   <= {WIDTH{1'b0}};
         dvs_r   <= {WIDTH{1'b0}};
         q_neg_r <= 1'b0;
         r_neg_r <= 1'b0;
         div0_r  <= 1'b0;
      end else if (accept_s) begin
         cnt_r   <= {CW{1'b0}};
         rem_r   <= {(WIDTH + 1){1'b0}};
         dvd_r   <= a_abs_s[WIDTH-1:0];
         dvs_r   <= b_abs_s[WIDTH-1:0];
         q_neg_r <= a_neg_s ^ b_neg_s;
         r_neg_r <= a_neg_s;
         div0_r  <= (divisor == {WIDTH{1'b0}});
      end else if (state_r == CALC) begin
         cnt_r <= cnt_r + CNT_ONE;
         rem_r <= rem_nxt_s;
         dvd_r <= dvd_nxt_s;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Result registers load on the final iteration and hold until the next completion.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         quotient  <= {WIDTH{1'b0}};
         remainder <= {WIDTH{1'b0}};
      end else if (last_s) begin
         quotient  <= q_fix_s;
         remainder <= r_fix_s;
      end else begin
         quotient  <= quotient;
         remainder <= remainder;
      end
   end

endmodule
